// File: rtl/ec1_pkg.sv
// Shared EC-1 definitions: opcode encodings and control-unit state encoding.
package ec1_pkg;

    localparam logic [2:0] OP_IN   = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;
    localparam logic [2:0] OP_JNZ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        START   = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        IN_ST   = 3'd3,
        OUT_ST  = 3'd4,
        DEC_ST  = 3'd5,
        JNZ_ST  = 3'd6,
        HALT_ST = 3'd7
    } state_t;

endpackage

// File: rtl/ec1_edge_detect.sv
// Rising-edge detector for the Enter key. The history flop resets to 1 so a
// key already held down across reset has to be released and pressed again.
module ec1_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic enter,
    output logic rise
);

    logic enter_hist_q;
    logic enter_hist_d;

    // History tracks the key every cycle, independent of the control state.
    always_comb begin
        enter_hist_d = enter;
    end

    // History register; reset to 1 to suppress a phantom edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            enter_hist_q <= 1'b1;
        end else begin
            enter_hist_q <= enter_hist_d;
        end
    end

    // Combinational rise so the IN load happens in the cycle the key goes high.
    always_comb begin
        rise = enter & ~enter_hist_q;
    end

endmodule

// File: rtl/ec1_control_unit.sv
// EC-1 control unit: fetch / decode / execute sequencer driving the datapath
// load and mux controls from the IR opcode field and the A==0 flag.
module ec1_control_unit
    import ec1_pkg::*;
#(
    parameter int OUT_HOLD   = 1,
    parameter bit WAIT_ENTER = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Enter,
    input  logic [2:0] IR7_5,
    input  logic       Aeq0,
    output logic       IRload,
    output logic       PCload,
    output logic       JNZmux,
    output logic       INmux,
    output logic       Aload,
    output logic       OutE,
    output logic       Halt,
    output state_t     dbg_state
);

    localparam int              CW        = $clog2(OUT_HOLD + 1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(OUT_HOLD - 1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            enter_rise;

    ec1_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .enter (Enter),
        .rise  (enter_rise)
    );

    // State and OUT hold counter registers; reset wins from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; every output defaults low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        IRload  = 1'b0;
        PCload  = 1'b0;
        JNZmux  = 1'b0;
        INmux   = 1'b0;
        Aload   = 1'b0;
        OutE    = 1'b0;
        Halt    = 1'b0;
        case (state_q)
            START: begin
                state_d = FETCH;
            end
            FETCH: begin
                // IR <= ROM[PC] and PC <= PC+1 on the same edge.
                IRload  = 1'b1;
                PCload  = 1'b1;
                JNZmux  = 1'b0;
                state_d = DECODE;
            end
            DECODE: begin
                case (IR7_5)
                    OP_IN:   state_d = IN_ST;
                    OP_OUT:  state_d = OUT_ST;
                    OP_DEC:  state_d = DEC_ST;
                    OP_JNZ:  state_d = JNZ_ST;
                    OP_HALT: state_d = HALT_ST;
                    default: state_d = FETCH;
                endcase
            end
            IN_ST: begin
                // Load happens in the same cycle the key edge is seen.
                if (!WAIT_ENTER || enter_rise) begin
                    INmux   = 1'b1;
                    Aload   = 1'b1;
                    state_d = FETCH;
                end
            end
            OUT_ST: begin
                OutE = 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DEC_ST: begin
                // A-1 path; the datapath wraps 0 to 255 on its own.
                INmux   = 1'b0;
                Aload   = 1'b1;
                state_d = FETCH;
            end
            JNZ_ST: begin
                JNZmux  = 1'b1;
                PCload  = ~Aeq0;
                state_d = FETCH;
            end
            HALT_ST: begin
                Halt = 1'b1;
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // Expose the current state for observation.
    always_comb begin
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_ec1_control_unit.sv
// Directed bench for the EC-1 control unit: one instance with OUT_HOLD=1 and
// Enter waiting (driven by a small datapath model for the program test), one
// with OUT_HOLD=4 and no Enter wait.
module tb_ec1_control_unit;
  import ec1_pkg::*;

  logic clk;
  int   errors = 0;
  int   checks = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT 1: OUT_HOLD=1, WAIT_ENTER=1 ----------------
  logic       rst1, enter1, aeq0_drv1, use_dp;
  logic [2:0] ir_drv1;
  logic       irload1, pcload1, jnzmux1, inmux1, aload1, oute1, halt1;
  state_t     st1;
  logic [2:0] ir7_5_1;
  logic       aeq0_1;

  // bench datapath model
  logic [7:0] rom [0:15];
  logic [7:0] dp_ir, dp_a, dp_in;
  logic [3:0] dp_pc;

  assign ir7_5_1 = use_dp ? dp_ir[7:5] : ir_drv1;
  assign aeq0_1  = use_dp ? (dp_a == 8'd0) : aeq0_drv1;

  ec1_control_unit #(.OUT_HOLD(1), .WAIT_ENTER(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .Enter(enter1), .IR7_5(ir7_5_1), .Aeq0(aeq0_1),
    .IRload(irload1), .PCload(pcload1), .JNZmux(jnzmux1), .INmux(inmux1),
    .Aload(aload1), .OutE(oute1), .Halt(halt1), .dbg_state(st1)
  );

  wire [6:0] o1 = {irload1, pcload1, jnzmux1, inmux1, aload1, oute1, halt1};

  always @(posedge clk) begin
    if (rst1) begin
      dp_pc <= 4'd0;
      dp_ir <= 8'd0;
      dp_a  <= 8'd0;
    end else if (use_dp) begin
      if (irload1) dp_ir <= rom[dp_pc];
      if (pcload1) dp_pc <= jnzmux1 ? dp_ir[3:0] : dp_pc + 4'd1;
      if (aload1)  dp_a  <= inmux1 ? dp_in : dp_a - 8'd1;
    end
  end

  // ---------------- DUT 4: OUT_HOLD=4, WAIT_ENTER=0 ----------------
  logic       rst4, enter4, aeq0_4;
  logic [2:0] ir4;
  logic       irload4, pcload4, jnzmux4, inmux4, aload4, oute4, halt4;
  state_t     st4;

  ec1_control_unit #(.OUT_HOLD(4), .WAIT_ENTER(1'b0)) dut4 (
    .clk(clk), .reset(rst4), .Enter(enter4), .IR7_5(ir4), .Aeq0(aeq0_4),
    .IRload(irload4), .PCload(pcload4), .JNZmux(jnzmux4), .INmux(inmux4),
    .Aload(aload4), .OutE(oute4), .Halt(halt4), .dbg_state(st4)
  );

  wire [6:0] o4 = {irload4, pcload4, jnzmux4, inmux4, aload4, oute4, halt4};

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1;
    tick(); tick();
    checks++;
    if (o1 !== 7'b0000000 || st1 !== START) begin
      errors++;
      $display("FAIL reset_start: outs=%b state=%0d exp outs=0000000 state=%0d", o1, st1, START);
    end
    checks++;
    if (o4 !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_start4: outs=%b exp 0000000", o4);
    end
    rst1 = 1'b0; rst4 = 1'b0;
    tick();
    checks++;
    if (st1 !== FETCH || o1 !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_fetch: outs=%b state=%0d exp outs=1100000 state=%0d", o1, st1, FETCH);
    end
  endtask

  task automatic test_in_wait();
    ir_drv1 = OP_IN;
    enter1  = 1'b0;
    tick();
    checks++;
    if (st1 !== DECODE || o1 !== 7'b0000000) begin
      errors++;
      $display("FAIL in_decode: outs=%b state=%0d exp 0000000 state=%0d", o1, st1, DECODE);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (st1 !== IN_ST || aload1 !== 1'b0) begin
        errors++;
        $display("FAIL in_hold_%0d: aload=%b state=%0d exp 0 state=%0d", i, aload1, st1, IN_ST);
      end
      tick();
    end
    enter1 = 1'b1;
    #1;
    checks++;
    if ({inmux1, aload1} !== 2'b11 || st1 !== IN_ST) begin
      errors++;
      $display("FAIL in_rise_load: inmux,aload=%b exp 11", {inmux1, aload1});
    end
    tick();
    checks++;
    if (st1 !== FETCH || aload1 !== 1'b0) begin
      errors++;
      $display("FAIL in_after_load: aload=%b state=%0d exp 0 state=%0d", aload1, st1, FETCH);
    end
    // Key held high through reset must not count as an edge.
    rst1 = 1'b1;
    tick(); tick();
    rst1 = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (st1 !== IN_ST || aload1 !== 1'b0) begin
      errors++;
      $display("FAIL in_held_reset: aload=%b state=%0d exp 0 state=%0d", aload1, st1, IN_ST);
    end
    enter1 = 1'b0;
    #1;
    checks++;
    if (aload1 !== 1'b0) begin
      errors++;
      $display("FAIL in_release: aload=%b exp 0", aload1);
    end
    tick();
    enter1 = 1'b1;
    #1;
    checks++;
    if ({inmux1, aload1} !== 2'b11) begin
      errors++;
      $display("FAIL in_repress: inmux,aload=%b exp 11", {inmux1, aload1});
    end
    tick();
  endtask

  task automatic test_nop();
    logic [2:0] ops [3];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010;
    for (int k = 0; k < 3; k++) begin
      ir_drv1 = ops[k];
      tick();
      checks++;
      if (st1 !== DECODE || o1 !== 7'b0000000) begin
        errors++;
        $display("FAIL nop_decode_%0d: outs=%b state=%0d exp 0000000 state=%0d", k, o1, st1, DECODE);
      end
      tick();
      checks++;
      if (st1 !== FETCH || o1 !== 7'b1100000) begin
        errors++;
        $display("FAIL nop_fetch_%0d: outs=%b state=%0d exp 1100000 state=%0d", k, o1, st1, FETCH);
      end
    end
  endtask

  task automatic test_dec_jnz_loop();
    int taken = 0, not_taken = 0, loads = 0, outs = 0;
    logic [7:0] out_a = 8'hxx;
    bit halted = 0;
    rom[0] = 8'h60; rom[1] = 8'hA0; rom[2] = 8'hC1; rom[3] = 8'h80; rom[4] = 8'hE0;
    for (int i = 5; i < 16; i++) rom[i] = 8'h00;
    dp_in  = 8'd3;
    enter1 = 1'b0;
    use_dp = 1'b1;
    rst1   = 1'b1;
    tick();
    rst1 = 1'b0;
    for (int cyc = 0; cyc < 200 && !halted; cyc++) begin
      tick();
      if (st1 == IN_ST && enter1 == 1'b0) begin
        enter1 = 1'b1;
        #1;
      end
      if (aload1) loads++;
      if (st1 == JNZ_ST && jnzmux1 === 1'b1) begin
        if (pcload1) taken++;
        else if (aeq0_1) not_taken++;
      end
      if (oute1) begin
        outs++;
        out_a = dp_a;
      end
      if (halt1) halted = 1;
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL loop_timeout: halt not reached in 200 cycles");
    end
    checks++;
    if (taken !== 2) begin
      errors++;
      $display("FAIL loop_taken: got %0d exp 2", taken);
    end
    checks++;
    if (not_taken !== 1) begin
      errors++;
      $display("FAIL loop_not_taken: got %0d exp 1", not_taken);
    end
    checks++;
    if (loads !== 4) begin
      errors++;
      $display("FAIL loop_aloads: got %0d exp 4", loads);
    end
    checks++;
    if (outs !== 1 || out_a !== 8'd0) begin
      errors++;
      $display("FAIL loop_out: count=%0d a=%0d exp count=1 a=0", outs, out_a);
    end
    checks++;
    if (dp_pc !== 4'd5) begin
      errors++;
      $display("FAIL loop_pc: got %0d exp 5", dp_pc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o1 !== 7'b0000001 || st1 !== HALT_ST) begin
        errors++;
        $display("FAIL halt_hold_%0d: outs=%b exp 0000001", i, o1);
      end
    end
    use_dp = 1'b0;
    enter1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    ir_drv1 = OP_IN;
    tick(); tick(); tick();
    checks++;
    if (st1 !== IN_ST) begin
      errors++;
      $display("FAIL mid_in_reach: state=%0d exp %0d", st1, IN_ST);
    end
    rst1 = 1'b1;
    tick();
    checks++;
    if (st1 !== START || o1 !== 7'b0000000) begin
      errors++;
      $display("FAIL mid_in_reset: outs=%b state=%0d exp 0000000 state=%0d", o1, st1, START);
    end
    rst1 = 1'b0;
    ir_drv1 = OP_HALT;
    tick();
    checks++;
    if (st1 !== FETCH || o1 !== 7'b1100000) begin
      errors++;
      $display("FAIL mid_in_fetch: outs=%b exp 1100000", o1);
    end
    tick(); tick();
    checks++;
    if (st1 !== HALT_ST || o1 !== 7'b0000001) begin
      errors++;
      $display("FAIL halt_enter: outs=%b state=%0d exp 0000001 state=%0d", o1, st1, HALT_ST);
    end
    rst1 = 1'b1;
    tick();
    checks++;
    if (st1 !== START || o1 !== 7'b0000000) begin
      errors++;
      $display("FAIL halt_reset: outs=%b exp 0000000", o1);
    end
    rst1 = 1'b0;
    tick();
    checks++;
    if (st1 !== FETCH || o1 !== 7'b1100000) begin
      errors++;
      $display("FAIL halt_refetch: outs=%b exp 1100000", o1);
    end
  endtask

  task automatic test_out_hold();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    ir4 = OP_OUT;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o4 !== 7'b0000010 || st4 !== OUT_ST) begin
        errors++;
        $display("FAIL out_hold_%0d: outs=%b exp 0000010", i, o4);
      end
    end
    tick();
    checks++;
    if (o4 !== 7'b1100000 || st4 !== FETCH) begin
      errors++;
      $display("FAIL out_end: outs=%b state=%0d exp 1100000 state=%0d", o4, st4, FETCH);
    end
    tick(); tick(); tick();
    checks++;
    if (o4 !== 7'b0000010) begin
      errors++;
      $display("FAIL out_cycle2: outs=%b exp 0000010", o4);
    end
    rst4 = 1'b1;
    tick();
    checks++;
    if (o4 !== 7'b0000000 || st4 !== START) begin
      errors++;
      $display("FAIL out_reset: outs=%b exp 0000000", o4);
    end
    rst4 = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o4 !== 7'b0000010) begin
        errors++;
        $display("FAIL out_rehold_%0d: outs=%b exp 0000010", i, o4);
      end
    end
    tick();
    checks++;
    if (o4 !== 7'b1100000) begin
      errors++;
      $display("FAIL out_reend: outs=%b exp 1100000", o4);
    end
  endtask

  task automatic test_in_nowait();
    ir4 = OP_IN;
    enter4 = 1'b0;
    tick(); tick();
    checks++;
    if (o4 !== 7'b0001100 || st4 !== IN_ST) begin
      errors++;
      $display("FAIL in_nowait: outs=%b exp 0001100", o4);
    end
    tick();
    checks++;
    if (o4 !== 7'b1100000) begin
      errors++;
      $display("FAIL in_nowait_fetch: outs=%b exp 1100000", o4);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    enter1 = 1'b0; enter4 = 1'b0;
    ir_drv1 = 3'b000; ir4 = 3'b000;
    aeq0_drv1 = 1'b0; aeq0_4 = 1'b0;
    use_dp = 1'b0;
    dp_in = 8'd0;
    test_reset();
    test_in_wait();
    test_nop();
    test_dec_jnz_loop();
    test_reset_mid();
    test_out_hold();
    test_in_nowait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
